sample_capture: RTL and testbench

- Upstream stage of the sample readout path. It samples the 8-bit ADC bus at a divided rate and writes samples into the 256-byte sample memory as a circular buffer.
- It holds a configurable pre-trigger history and detects a level-crossing trigger, then fills the rest of the buffer.
- When the buffer is complete it pulses done and reports start_addr, the address of the oldest stored sample. The downstream reader drains the memory over UART.

---
 rtl/sample_capture.sv | 130 +++++++++++++
 tb/tb_sample_capture.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture.sv
// Divided-rate ADC sampler writing a circular sample buffer with pre-trigger
// history and level-crossing trigger; pulses done with the oldest-sample address.
module sample_capture #(
   parameter int ADDR_W  = 8,
   parameter int PRETRIG = 32,
   parameter int DIV     = 50
) (
   input  logic              clk_50mhz,
   input  logic              reset,
   input  logic              arm,
   input  logic              force_trig,
   input  logic              trig_rising,
   input  logic [7:0]        trig_level,
   input  logic [7:0]        adc_data,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [7:0]        mem_wr_data,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] start_addr
);

   // state    | meaning
   // S_IDLE   | waiting for arm after reset
   // S_PRETRIG| filling the pre-trigger history, no trigger evaluation
   // S_ARMED  | writing freely, watching for a trigger
   // S_POST   | filling the remainder of the buffer after the trigger
   // S_DONE   | buffer complete, start_addr valid, waiting for re-arm

   localparam int DEPTH  = 2**ADDR_W;
   localparam int POST_N = DEPTH - PRETRIG;
   localparam int DIV_W  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PRETRIG, S_ARMED, S_POST, S_DONE
   } state_t;

   state_t            r_state;
   logic [DIV_W-1:0]  r_div;
   logic [ADDR_W-1:0] r_wp;
   logic [ADDR_W-1:0] r_trig_addr;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_prev;
   logic [7:0]        r_level;
   logic              r_rising;

   logic              w_strobe;
   logic              w_cross;
   logic              w_trig;
   logic              w_last;
   logic [ADDR_W-1:0] w_start;

   assign w_strobe = (r_div == DIV_W'(DIV - 1));
   assign w_cross  = r_rising ? ((r_prev < r_level) && (adc_data >= r_level))
                              : ((r_prev > r_level) && (adc_data <= r_level));
   assign w_trig   = w_cross | force_trig;

   // The trigger sample counts toward the post-trigger fill, so a capture can
   // finish on the trigger strobe itself when only one post sample is needed.
   assign w_last   = w_strobe &&
                     (((r_state == S_ARMED) && w_trig && (POST_N == 1)) ||
                      ((r_state == S_POST) && (r_cnt == CNT_W'(POST_N - 1))));
   assign w_start  = ((r_state == S_ARMED) ? r_wp : r_trig_addr) - ADDR_W'(PRETRIG);

   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_div       <= '0;
         r_wp        <= '0;
         r_trig_addr <= '0;
         r_cnt       <= '0;
         r_prev      <= '0;
         r_level     <= '0;
         r_rising    <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_we      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         start_addr  <= '0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         r_div  <= w_strobe ? '0 : r_div + DIV_W'(1);
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  r_state  <= S_PRETRIG;
                  r_level  <= trig_level;
                  r_rising <= trig_rising;
                  r_wp     <= '0;
                  r_cnt    <= '0;
                  r_div    <= '0;
                  busy     <= 1'b1;
               end
            end
            default: begin
               if (w_strobe) begin
                  mem_we      <= 1'b1;
                  mem_wr_addr <= r_wp;
                  mem_wr_data <= adc_data;
                  r_wp        <= r_wp + ADDR_W'(1);
                  r_prev      <= adc_data;
                  if (r_state == S_PRETRIG) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                     if (r_cnt == CNT_W'(PRETRIG - 1))
                        r_state <= S_ARMED;
                  end else if (r_state == S_ARMED) begin
                     if (w_trig) begin
                        r_trig_addr <= r_wp;
                        r_cnt       <= CNT_W'(1);
                        r_state     <= S_POST;
                     end
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
                  if (w_last) begin
                     r_state    <= S_DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     start_addr <= w_start;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: sample-level model checked every cycle, plus
// hand-computed expectations for each directed capture scenario.
module tb_sample_capture;

   localparam int ADDR_W  = 8;
   localparam int DEPTH   = 256;
   localparam int PRETRIG = 32;
   localparam int DIV     = 2;
   localparam int POST_N  = DEPTH - PRETRIG;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              arm = 1'b0;
   logic              force_trig = 1'b0;
   logic              trig_rising = 1'b1;
   logic [7:0]        trig_level = 8'd0;
   logic [7:0]        adc_data = 8'd0;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [7:0]        mem_wr_data;
   logic              mem_we;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] start_addr;

   always #5 clk = ~clk;

   sample_capture #(.ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .DIV(DIV)) dut (
      .clk_50mhz  (clk),
      .reset      (reset),
      .arm        (arm),
      .force_trig (force_trig),
      .trig_rising(trig_rising),
      .trig_level (trig_level),
      .adc_data   (adc_data),
      .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .mem_we     (mem_we),
      .busy       (busy),
      .done       (done),
      .start_addr (start_addr)
   );

   int n_checks = 0;
   int n_err    = 0;
   int mode     = 0;
   bit force_en = 1'b0;

   // Model: capture in progress, cycles since arm, samples taken, trigger sample index
   bit m_cap = 1'b0;
   int m_k = 0, m_n = 0, m_trig = -1, m_prev = 0, m_level = 0;
   bit m_rising = 1'b0;
   bit e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   int e_addr = 0, e_data = 0, e_start = 0;

   logic [7:0] mem [DEPTH];
   int we_total = 0, done_total = 0, last_addr = 0, done_addr = 0;

   function automatic int exp_val(input int md, input int n);
      case (md)
         0:       return n % 256;
         1:       return (255 - n) & 255;
         default: return 7;
      endcase
   endfunction

   function automatic bit crossed(input bit rise, input int lvl, input int p, input int c);
      if (rise) return (p < lvl) && (c >= lvl);
      return (p > lvl) && (c <= lvl);
   endfunction

   always @(posedge clk) begin
      int v;
      e_we   = 1'b0;
      e_done = 1'b0;
      if (reset) begin
         m_cap = 1'b0; m_prev = 0; e_busy = 1'b0; e_start = 0; e_addr = 0; e_data = 0;
      end else if (!m_cap) begin
         if (arm) begin
            m_cap = 1'b1; m_k = 0; m_n = 0; m_trig = -1;
            m_level = int'(trig_level); m_rising = trig_rising; e_busy = 1'b1;
         end
      end else begin
         m_k++;
         if (m_k % DIV == 0) begin
            v = int'(adc_data);
            e_we = 1'b1; e_addr = m_n % DEPTH; e_data = v;
            if (m_trig < 0 && m_n >= PRETRIG &&
                (force_trig || crossed(m_rising, m_level, m_prev, v)))
               m_trig = m_n;
            m_prev = v;
            m_n++;
            if (m_trig >= 0 && m_n - m_trig == POST_N) begin
               e_done = 1'b1; e_busy = 1'b0; m_cap = 1'b0;
               e_start = (m_trig - PRETRIG + DEPTH) % DEPTH;
            end
         end
      end
   end

   // ADC stimulus follows the sample index the model is about to take
   always @(negedge clk) begin
      adc_data   = 8'(exp_val(mode, m_n));
      force_trig = force_en && m_cap && (m_n == 40);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("busy", 32'(busy), 32'(e_busy));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("done", 32'(done), 32'(e_done));
      if (e_we) begin
         check("wr_addr", 32'(mem_wr_addr), e_addr);
         check("wr_data", 32'(mem_wr_data), e_data);
      end
      if (!m_cap) check("start_addr", 32'(start_addr), e_start);
      if (mem_we) begin
         mem[mem_wr_addr] = mem_wr_data;
         we_total++;
         last_addr = int'(mem_wr_addr);
      end
      if (done) begin
         done_total++;
         done_addr = int'(mem_wr_addr);
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   // Inputs are scrambled after arm so a design that kept using them would misbehave
   task automatic do_arm(input int lvl, input bit rise);
      trig_level  = 8'(lvl);
      trig_rising = rise;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      trig_level  = ~8'(lvl);
      trig_rising = ~rise;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("done_within_budget", 32'(seen), 32'd1);
   endtask

   task automatic wait_n(input int n, input int budget);
      for (int i = 0; i < budget && m_n < n; i++) tick();
      check("sample_count_reached", 32'(m_n >= n), 32'd1);
   endtask

   task automatic check_buffer(input string nm, input int first_n);
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         int n = first_n + i;
         if (mem[n % DEPTH] !== 8'(exp_val(mode, n))) bad++;
      end
      check(nm, bad, 0);
   endtask

   task automatic run_capture(input string nm, input int lvl, input bit rise,
                              input int x_start, input int x_writes, input int x_last);
      int wb = we_total;
      int db = done_total;
      do_arm(lvl, rise);
      wait_done(2000);
      repeat (3) tick();
      check({nm, "_start_addr"}, 32'(start_addr), x_start);
      check({nm, "_writes"}, we_total - wb, x_writes);
      check({nm, "_done_count"}, done_total - db, 1);
      check({nm, "_last_addr"}, done_addr, x_last);
      check_buffer({nm, "_buffer"}, x_writes - DEPTH);
   endtask

   initial begin
      int wb, db;
      do_reset(3);
      check("rst_busy", 32'(busy), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_done", 32'(done), 0);
      check("rst_start_addr", 32'(start_addr), 0);
      check("rst_wr_addr", 32'(mem_wr_addr), 0);
      repeat (2) tick();

      // Rising ramp: trigger at addr 100, 324 writes ending at 67, start 68
      mode = 0;
      run_capture("ramp", 100, 1'b1, 68, 324, 67);

      // Falling ramp re-armed from DONE: trigger at addr 205, start 173
      mode = 1;
      run_capture("fall", 50, 1'b0, 173, 429, 172);

      // Forced trigger on sample 40 with no crossing: start 8
      mode = 2;
      force_en = 1'b1;
      run_capture("force", 100, 1'b1, 8, 264, 7);
      force_en = 1'b0;

      // No trigger for 600 strobes: wp wraps, busy holds, no done
      wb = we_total;
      db = done_total;
      do_arm(100, 1'b1);
      wait_n(600, 1400);
      check("notrig_writes", we_total - wb, 600);
      check("notrig_last_addr", last_addr, 599 % 256);
      check("notrig_done_count", done_total - db, 0);
      check("notrig_busy", 32'(busy), 1);
      do_reset(2);
      repeat (2) tick();

      // Arm with a new level while ARMED must be ignored
      mode = 0;
      wb = we_total;
      db = done_total;
      do_arm(100, 1'b1);
      wait_n(50, 300);
      trig_level = 8'd10;
      arm = 1'b1;
      repeat (2) tick();
      arm = 1'b0;
      wait_done(2000);
      repeat (2) tick();
      check("armign_start_addr", 32'(start_addr), 68);
      check("armign_writes", we_total - wb, 324);
      check("armign_done_count", done_total - db, 1);

      // Reset during POST, then a full capture from wp=0
      db = done_total;
      do_arm(100, 1'b1);
      wait_n(150, 600);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_mem_we", 32'(mem_we), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_start_addr", 32'(start_addr), 0);
      repeat (3) tick();
      check("midrst_done_count", done_total - db, 0);
      run_capture("after_rst", 100, 1'b1, 68, 324, 67);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
